// File: rtl/dmem_ctrl_pkg.sv
// Shared widths, state encoding and sentinel values for the MEM-stage data-memory controller.
package dmem_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int RD_WIDTH   = 5;

  // Destination index 32 is outside the register file and marks "no write-back target".
  localparam logic [RD_WIDTH:0] RD_NONE = 6'd32;

  typedef enum logic [1:0] {
    DMEM_IDLE        = 2'd0,
    DMEM_WAIT_GNT    = 2'd1,
    DMEM_WAIT_RVALID = 2'd2
  } dmem_state_e;

  function automatic logic [ADDR_WIDTH-1:0] wordAlign(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane logic: store enables/replication, load extraction/extension and misalignment detection.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]            offset_i,
  input  logic                  half_i,
  input  logic                  byte_i,
  input  logic                  unsigned_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [3:0]            store_be_o,
  output logic [DATA_WIDTH-1:0] store_wdata_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  misaligned_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = rdata_i[{offset_i, 3'b000} +: 8];
  assign halfSel = rdata_i[{offset_i[1], 4'b0000} +: 16];

  // Word accesses are the default; byte wins if both size qualifiers are set.
  always_comb begin
    store_be_o    = 4'b1111;
    store_wdata_o = store_data_i;
    load_data_o   = rdata_i;
    misaligned_o  = 1'b0;
    if (byte_i) begin
      store_be_o    = 4'b0001 << offset_i;
      store_wdata_o = {4{store_data_i[7:0]}};
      load_data_o   = {{24{~unsigned_i & byteSel[7]}}, byteSel};
    end else if (half_i) begin
      store_be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
      store_wdata_o = {2{store_data_i[15:0]}};
      load_data_o   = {{16{~unsigned_i & halfSel[15]}}, halfSel};
      misaligned_o  = offset_i[0];
    end else begin
      misaligned_o  = |offset_i;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage controller: issues data-memory bus requests, stalls EX while an access is outstanding,
// and registers the completed result toward write-back.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
(
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  ex_valid,
  output logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] alu_result_mem,
  input  logic [ADDR_WIDTH-1:0] mem_addr_mem,
  input  logic [RD_WIDTH:0]     rd_mem,
  input  logic                  load_mem,
  input  logic                  store_mem,
  input  logic                  mem_H_mem,
  input  logic                  mem_B_mem,
  input  logic                  mem_U_mem,
  input  logic [DATA_WIDTH-1:0] store_data_mem,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wb_valid,
  output logic [RD_WIDTH:0]     rd_wb,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  misalign_err
);

  dmem_state_e state_q, state_d;

  logic                  wbValid_q, wbValid_d;
  logic                  misalign_q, misalign_d;
  logic [RD_WIDTH:0]     rdWb_q, rdWb_d;
  logic [DATA_WIDTH-1:0] wbData_q, wbData_d;

  logic                  memOp;
  logic                  misaligned;
  logic [3:0]            storeBe;
  logic [DATA_WIDTH-1:0] storeWdata;
  logic [DATA_WIDTH-1:0] loadData;

  assign memOp = ex_valid & (load_mem | store_mem);

  dmem_lane_align u_lane_align (
    .offset_i      (mem_addr_mem[1:0]),
    .half_i        (mem_H_mem),
    .byte_i        (mem_B_mem),
    .unsigned_i    (mem_U_mem),
    .store_data_i  (store_data_mem),
    .rdata_i       (dmem_rdata),
    .store_be_o    (storeBe),
    .store_wdata_o (storeWdata),
    .load_data_o   (loadData),
    .misaligned_o  (misaligned)
  );

  // Bus outputs are driven purely from the held EX fields, so they stay stable while waiting for gnt.
  always_comb begin
    state_d    = state_q;
    mem_ready  = 1'b1;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = '0;
    dmem_wdata = '0;
    wbValid_d  = 1'b0;
    misalign_d = 1'b0;
    rdWb_d     = rdWb_q;
    wbData_d   = wbData_q;

    case (state_q)
      DMEM_IDLE, DMEM_WAIT_GNT: begin
        if (memOp && misaligned) begin
          state_d    = DMEM_IDLE;
          wbValid_d  = 1'b1;
          misalign_d = 1'b1;
          rdWb_d     = RD_NONE;
          wbData_d   = mem_addr_mem;
        end else if (memOp) begin
          dmem_req   = 1'b1;
          dmem_we    = store_mem;
          dmem_addr  = wordAlign(mem_addr_mem);
          dmem_be    = store_mem ? storeBe : 4'b1111;
          dmem_wdata = store_mem ? storeWdata : '0;
          mem_ready  = 1'b0;
          state_d    = DMEM_WAIT_GNT;
          if (dmem_gnt && store_mem) begin
            mem_ready = 1'b1;
            state_d   = DMEM_IDLE;
            wbValid_d = 1'b1;
            rdWb_d    = rd_mem;
            wbData_d  = alu_result_mem;
          end else if (dmem_gnt) begin
            state_d   = DMEM_WAIT_RVALID;
          end
        end else begin
          state_d = DMEM_IDLE;
          if (ex_valid) begin
            wbValid_d = 1'b1;
            rdWb_d    = rd_mem;
            wbData_d  = alu_result_mem;
          end
        end
      end

      DMEM_WAIT_RVALID: begin
        mem_ready = 1'b0;
        if (dmem_rvalid) begin
          mem_ready = 1'b1;
          state_d   = DMEM_IDLE;
          wbValid_d = 1'b1;
          rdWb_d    = rd_mem;
          wbData_d  = loadData;
        end
      end

      default: state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q    <= DMEM_IDLE;
      wbValid_q  <= 1'b0;
      misalign_q <= 1'b0;
      rdWb_q     <= RD_NONE;
      wbData_q   <= '0;
    end else begin
      state_q    <= state_d;
      wbValid_q  <= wbValid_d;
      misalign_q <= misalign_d;
      rdWb_q     <= rdWb_d;
      wbData_q   <= wbData_d;
    end
  end

  assign wb_valid     = wbValid_q;
  assign misalign_err = misalign_q;
  assign rd_wb        = rdWb_q;
  assign wb_data      = wbData_q;

endmodule
